// File: rtl/float_class_pipe.sv
// Streaming IEEE-754 operand classifier with a two-stage valid/ready pipeline.
// Reports a one-hot class plus sign/quiet-NaN flags and keeps saturating per-class counters.
module float_class_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   in_num,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              out_type,
    output logic                    out_sign,
    output logic                    out_qnan,
    input  logic                    cnt_clr,
    input  logic [2:0]              cnt_sel,
    output logic [CNT_W-1:0]        cnt_val
);
    localparam int NUM_W = 1 + EXP_W + FRAC_W;
    localparam int NCLS  = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               in_sign;
    logic [EXP_W-1:0]   in_exp;
    logic [FRAC_W-1:0]  in_frac;

    logic s1_v_reg, s1_sign_reg, s1_exp_all1_reg, s1_exp_all0_reg;
    logic s1_frac_zero_reg, s1_frac_msb_reg;
    logic out_valid_reg, out_sign_reg, out_qnan_reg;
    logic [4:0] out_type_reg;
    logic [4:0] type_next;
    logic       qnan_next;
    logic s1_adv, s2_adv, out_hs;
    logic [NCLS-1:0][CNT_W-1:0] cnt_all;

    assign in_sign = in_num[NUM_W-1];
    assign in_exp  = in_num[FRAC_W +: EXP_W];
    assign in_frac = in_num[FRAC_W-1:0];

    assign s2_adv   = s1_v_reg && (!out_valid_reg || out_ready);
    assign in_ready = !s1_v_reg || s2_adv;
    assign s1_adv   = in_valid && in_ready;
    assign out_hs   = out_valid_reg && out_ready;

    assign out_valid = out_valid_reg;
    assign out_type  = out_type_reg;
    assign out_sign  = out_sign_reg;
    assign out_qnan  = out_qnan_reg;

    // Stage 1 only captures reduction flags so stage 2 never touches the wide operand.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v_reg         <= 1'b0;
            s1_sign_reg      <= 1'b0;
            s1_exp_all1_reg  <= 1'b0;
            s1_exp_all0_reg  <= 1'b0;
            s1_frac_zero_reg <= 1'b0;
            s1_frac_msb_reg  <= 1'b0;
        end else begin
            s1_v_reg <= s1_adv || (s1_v_reg && !s2_adv);
            if (s1_adv) begin
                s1_sign_reg      <= in_sign;
                s1_exp_all1_reg  <= &in_exp;
                s1_exp_all0_reg  <= ~|in_exp;
                s1_frac_zero_reg <= ~|in_frac;
                s1_frac_msb_reg  <= in_frac[FRAC_W-1];
            end
        end
    end

    always_comb begin
        type_next = 5'b00010;
        qnan_next = 1'b0;
        if (s1_exp_all1_reg) begin
            type_next = s1_frac_zero_reg ? 5'b01000 : 5'b10000;
            qnan_next = !s1_frac_zero_reg && s1_frac_msb_reg;
        end else if (s1_exp_all0_reg) begin
            type_next = s1_frac_zero_reg ? 5'b00001 : 5'b00100;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg <= 1'b0;
            out_type_reg  <= 5'b0;
            out_sign_reg  <= 1'b0;
            out_qnan_reg  <= 1'b0;
        end else begin
            out_valid_reg <= s2_adv || (out_valid_reg && !out_ready);
            if (s2_adv) begin
                out_type_reg <= type_next;
                out_sign_reg <= s1_sign_reg;
                out_qnan_reg <= qnan_next;
            end
        end
    end

    // Clear has priority over a same-cycle increment; counters stick at all-ones.
    genvar gi;
    generate
        for (gi = 0; gi < NCLS; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else if (cnt_clr) begin
                    cnt_reg <= '0;
                end else if (out_hs && out_type_reg[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign cnt_all[gi] = cnt_reg;
        end
    endgenerate

    always_comb begin
        cnt_val = '0;
        case (cnt_sel)
            3'd0:    cnt_val = cnt_all[0];
            3'd1:    cnt_val = cnt_all[1];
            3'd2:    cnt_val = cnt_all[2];
            3'd3:    cnt_val = cnt_all[3];
            3'd4:    cnt_val = cnt_all[4];
            default: cnt_val = '0;
        endcase
    end
endmodule
